// File: rtl/alu_pkg.sv
// ALU operation encoding shared by the ALU and the control units that drive it.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluMul = 4'd3,
    AluAnd = 4'd4,
    AluOr  = 4'd5,
    AluXor = 4'd7,
    AluShl = 4'd8,
    AluShr = 4'd9
  } ALU_ctrl_e;

endpackage

// File: rtl/mips_ctrl_pkg.sv
// State encoding, opcode/funct constants and mux-select values for the multi-cycle
// MIPS control unit.
package mips_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch   = 4'd0;
  localparam state_t StDecode  = 4'd1;
  localparam state_t StMemAdr  = 4'd2;
  localparam state_t StMemRd   = 4'd3;
  localparam state_t StMemWb   = 4'd4;
  localparam state_t StMemWr   = 4'd5;
  localparam state_t StRtypeEx = 4'd6;
  localparam state_t StAluWb   = 4'd7;
  localparam state_t StBranch  = 4'd8;
  localparam state_t StAddiEx  = 4'd9;
  localparam state_t StAddiWb  = 4'd10;
  localparam state_t StJump    = 4'd11;
  localparam state_t StFault   = 4'd12;

  localparam logic [5:0] OpRtype    = 6'h00;
  localparam logic [5:0] OpSpecial2 = 6'h1C;
  localparam logic [5:0] OpLw       = 6'h23;
  localparam logic [5:0] OpSw       = 6'h2B;
  localparam logic [5:0] OpBeq      = 6'h04;
  localparam logic [5:0] OpAddi     = 6'h08;
  localparam logic [5:0] OpJ        = 6'h02;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnMul = 6'h02;

  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  localparam logic [1:0] SrcBRt    = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  // States that drive the ALU and are stretched over its register latency.
  function automatic logic is_alu_state(state_t s);
    return s inside {StFetch, StDecode, StMemAdr, StRtypeEx, StBranch, StAddiEx};
  endfunction

endpackage

// File: rtl/mips_ctrl_funct_dec.sv
// Combinational R-type decoder: (opcode, funct) -> ALU operation, illegal flag and
// whether the operation can raise an arithmetic overflow.
module mips_ctrl_funct_dec
  import alu_pkg::*;
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ALU_ctrl_e  alu_ctrl,
  output logic       illegal,
  output logic       ovf_op
);

  always_comb begin
    alu_ctrl = AluAdd;
    illegal  = 1'b0;
    if (opcode == OpRtype) begin
      case (funct)
        FnAdd:   alu_ctrl = AluAdd;
        FnSub:   alu_ctrl = AluSub;
        FnAnd:   alu_ctrl = AluAnd;
        FnOr:    alu_ctrl = AluOr;
        FnXor:   alu_ctrl = AluXor;
        FnSll:   alu_ctrl = AluShl;
        FnSrl:   alu_ctrl = AluShr;
        default: illegal  = 1'b1;
      endcase
    end else if (opcode == OpSpecial2 && funct == FnMul) begin
      alu_ctrl = AluMul;
    end else begin
      illegal = 1'b1;
    end
  end

  assign ovf_op = !illegal && (alu_ctrl inside {AluAdd, AluSub, AluMul});

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM with ALU latency stretch and memory handshake.
// Optional overflow trap enabled by defining MIPS_CTRL_OVF_TRAP_EN.
module mips_ctrl_fsm
  import alu_pkg::*;
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_f,
  input  logic       overflow_f,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_en,
  output ALU_ctrl_e  alu_ctrl,
  output logic       fault
);

  localparam logic [1:0] LastCnt = 2'(ALU_LATENCY);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  ALU_ctrl_e funct_alu_ctrl;
  logic      funct_illegal, funct_ovf_op;
  logic      alu_state, alu_last, handshake, ovf_trap;
  logic      mem_req_raw, mem_we_raw, ir_we_raw, pc_we_raw, reg_we_raw;

  mips_ctrl_funct_dec u_funct_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (funct_alu_ctrl),
    .illegal  (funct_illegal),
    .ovf_op   (funct_ovf_op)
  );

`ifdef MIPS_CTRL_OVF_TRAP_EN
  assign ovf_trap = overflow_f;
`else
  logic unused_overflow_f;
  assign unused_overflow_f = overflow_f;
  assign ovf_trap          = 1'b0;
`endif

  assign alu_state = is_alu_state(state_q);
  assign alu_last  = (cnt_q == LastCnt);

  assign mem_req_raw = (state_q == StFetch && !done_q) || (state_q == StMemRd) ||
                       (state_q == StMemWr);

  // Strobes are suppressed while reset is held; everything else shows FETCH values.
  assign mem_req   = mem_req_raw & ~rst;
  assign mem_we    = mem_we_raw  & ~rst;
  assign ir_we     = ir_we_raw   & ~rst;
  assign pc_we     = pc_we_raw   & ~rst;
  assign reg_we    = reg_we_raw  & ~rst;
  assign handshake = mem_req & mem_ready;
  assign alu_en    = alu_state;

  always_comb begin
    mem_we_raw = 1'b0;
    iord       = 1'b0;
    ir_we_raw  = 1'b0;
    pc_we_raw  = 1'b0;
    pc_src     = PcAlu;
    reg_we_raw = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBRt;
    alu_ctrl   = AluAdd;
    fault      = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b = SrcBFour;
        ir_we_raw = handshake;
        pc_we_raw = (done_q | handshake) & alu_last;
      end
      StDecode:  alu_src_b = SrcBImmSh;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd:   iord = 1'b1;
      StMemWb: begin
        reg_we_raw = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_we_raw = 1'b1;
        iord       = 1'b1;
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu_ctrl;
      end
      StAluWb: begin
        reg_we_raw = 1'b1;
        reg_dst    = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_ctrl  = AluSub;
        pc_src    = PcAluOut;
        pc_we_raw = zero_f & alu_last;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StAddiWb:  reg_we_raw = 1'b1;
      StJump: begin
        pc_we_raw = 1'b1;
        pc_src    = PcJump;
      end
      StFault:   fault = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (alu_state && !alu_last) begin
      cnt_d = cnt_q + 2'd1;
    end
    case (state_q)
      StFetch: begin
        if (handshake) done_d = 1'b1;
        if ((done_q | handshake) && alu_last) state_d = StDecode;
      end
      StDecode: begin
        if (alu_last) begin
          case (opcode)
            OpLw, OpSw:          state_d = StMemAdr;
            OpRtype, OpSpecial2: state_d = StRtypeEx;
            OpBeq:               state_d = StBranch;
            OpAddi:              state_d = StAddiEx;
            OpJ:                 state_d = StJump;
            default:             state_d = StFault;
          endcase
        end
      end
      StMemAdr:  if (alu_last) state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (handshake) state_d = StMemWb;
      StMemWr:   if (handshake) state_d = StFetch;
      StRtypeEx: begin
        if (alu_last) begin
          state_d = (funct_illegal || (ovf_trap && funct_ovf_op)) ? StFault : StAluWb;
        end
      end
      StBranch:  if (alu_last) state_d = StFetch;
      StAddiEx:  if (alu_last) state_d = ovf_trap ? StFault : StAddiWb;
      StMemWb, StAluWb, StAddiWb, StJump: state_d = StFetch;
      StFault:   state_d = StFault;
      default:   state_d = StFetch;
    endcase
    if (state_d != state_q) begin
      cnt_d  = 2'd0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: one instance at ALU_LATENCY=0, one at ALU_LATENCY=2,
// both fed the same stimulus; each step checks the instance it targets.
module tb_mips_ctrl_fsm;
  import alu_pkg::*;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       zero_f, overflow_f, mem_ready;

  logic       a_mem_req, a_mem_we, a_iord, a_ir_we, a_pc_we, a_reg_we, a_reg_dst;
  logic       a_mem_to_reg, a_alu_src_a, a_alu_en, a_fault;
  logic [1:0] a_pc_src, a_alu_src_b;
  ALU_ctrl_e  a_alu_ctrl;

  logic       b_mem_req, b_mem_we, b_iord, b_ir_we, b_pc_we, b_reg_we, b_reg_dst;
  logic       b_mem_to_reg, b_alu_src_a, b_alu_en, b_fault;
  logic [1:0] b_pc_src, b_alu_src_b;
  ALU_ctrl_e  b_alu_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  mips_ctrl_fsm #(.ALU_LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero_f(zero_f),
    .overflow_f(overflow_f), .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .iord(a_iord), .ir_we(a_ir_we), .pc_we(a_pc_we), .pc_src(a_pc_src), .reg_we(a_reg_we),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .alu_en(a_alu_en), .alu_ctrl(a_alu_ctrl), .fault(a_fault)
  );

  mips_ctrl_fsm #(.ALU_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero_f(zero_f),
    .overflow_f(overflow_f), .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .iord(b_iord), .ir_we(b_ir_we), .pc_we(b_pc_we), .pc_src(b_pc_src), .reg_we(b_reg_we),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_en(b_alu_en), .alu_ctrl(b_alu_ctrl), .fault(b_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  // Leaves both instances in FETCH, cnt=0, 1 time unit after reset release.
  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h20;
    zero_f = 1'b0; overflow_f = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_mem_req", a_mem_req, 1'b0);
    chk("rst_ir_we", a_ir_we, 1'b0);
    chk("rst_pc_we", a_pc_we, 1'b0);
    chk("rst_alu_src_b", a_alu_src_b, 2'd1);
    chk("rst_fault", a_fault, 1'b0);
    chk("rst_b_mem_req", b_mem_req, 1'b0);

    // R-type add, latency 0; latency-2 instance checked in FETCH alongside
    do_reset();
    chk("add_fetch_req", a_mem_req, 1'b1);
    chk("add_fetch_ir_we", a_ir_we, 1'b1);
    chk("add_fetch_pc_we", a_pc_we, 1'b1);
    chk("l2_fetch0_ir_we", b_ir_we, 1'b1);
    chk("l2_fetch0_pc_we", b_pc_we, 1'b0);
    cyc();
    chk("add_dec_src_b", a_alu_src_b, 2'd3);
    chk("add_dec_req", a_mem_req, 1'b0);
    chk("l2_fetch1_req_drop", b_mem_req, 1'b0);
    chk("l2_fetch1_pc_we", b_pc_we, 1'b0);
    cyc();
    chk("add_ex_ctrl", a_alu_ctrl, 4'd0);
    chk("add_ex_src_a", a_alu_src_a, 1'b1);
    chk("add_ex_alu_en", a_alu_en, 1'b1);
    chk("add_ex_reg_we", a_reg_we, 1'b0);
    chk("l2_fetch2_pc_we", b_pc_we, 1'b1);
    cyc();
    chk("add_wb_reg_we", a_reg_we, 1'b1);
    chk("add_wb_reg_dst", a_reg_dst, 1'b1);
    chk("add_wb_alu_en", a_alu_en, 1'b0);
    cyc();
    chk("add_next_fetch", a_mem_req, 1'b1);

    // beq taken / not taken
    opcode = 6'h04; zero_f = 1'b1;
    do_reset(); cyc(); cyc();
    chk("beq_t_pc_we", a_pc_we, 1'b1);
    chk("beq_t_pc_src", a_pc_src, 2'd1);
    chk("beq_t_sub", a_alu_ctrl, 4'd1);
    cyc();
    chk("beq_t_back_fetch", a_pc_src, 2'd0);
    zero_f = 1'b0;
    do_reset(); cyc(); cyc();
    chk("beq_nt_pc_we", a_pc_we, 1'b0);
    chk("beq_nt_pc_src", a_pc_src, 2'd1);

    // lw with three wait cycles in MEM_RD
    opcode = 6'h23;
    do_reset(); cyc();
    mem_ready = 1'b0;
    cyc();
    chk("lw_adr_src_a", a_alu_src_a, 1'b1);
    chk("lw_adr_src_b", a_alu_src_b, 2'd2);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("lw_rd_wait_req", a_mem_req, 1'b1);
      chk("lw_rd_wait_iord", a_iord, 1'b1);
      chk("lw_rd_wait_ir_we", a_ir_we, 1'b0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_rd_hs_req", a_mem_req, 1'b1);
    cyc();
    chk("lw_wb_m2r", a_mem_to_reg, 1'b1);
    chk("lw_wb_reg_we", a_reg_we, 1'b1);
    chk("lw_wb_reg_dst", a_reg_dst, 1'b0);
    chk("lw_wb_req", a_mem_req, 1'b0);

    // sw
    opcode = 6'h2B;
    do_reset(); cyc(); cyc(); cyc();
    chk("sw_wr_we", a_mem_we, 1'b1);
    chk("sw_wr_req", a_mem_req, 1'b1);
    chk("sw_wr_iord", a_iord, 1'b1);
    cyc();
    chk("sw_fetch_we", a_mem_we, 1'b0);
    chk("sw_fetch_iord", a_iord, 1'b0);

    // j
    opcode = 6'h02;
    do_reset(); cyc(); cyc();
    chk("j_pc_we", a_pc_we, 1'b1);
    chk("j_pc_src", a_pc_src, 2'd2);
    chk("j_alu_en", a_alu_en, 1'b0);
    cyc();
    chk("j_next_fetch", a_alu_src_b, 2'd1);

    // addi
    opcode = 6'h08;
    do_reset(); cyc(); cyc();
    chk("addi_ex_src_b", a_alu_src_b, 2'd2);
    chk("addi_ex_reg_we", a_reg_we, 1'b0);
    cyc();
    chk("addi_wb_reg_we", a_reg_we, 1'b1);
    chk("addi_wb_reg_dst", a_reg_dst, 1'b0);

    // AND with ALU_LATENCY=2
    opcode = 6'h00; funct = 6'h24;
    do_reset();
    chk("l2_and_f0_pc_we", b_pc_we, 1'b0);
    cyc(); cyc();
    chk("l2_and_f2_pc_we", b_pc_we, 1'b1);
    cyc();
    chk("l2_and_dec_src_b", b_alu_src_b, 2'd3);
    cyc(); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      chk("l2_and_ex_alu_en", b_alu_en, 1'b1);
      chk("l2_and_ex_ctrl", b_alu_ctrl, 4'd4);
      chk("l2_and_ex_reg_we", b_reg_we, 1'b0);
      cyc();
    end
    chk("l2_and_wb_reg_we", b_reg_we, 1'b1);
    chk("l2_and_wb_reg_dst", b_reg_dst, 1'b1);

    // Other R-type encodings
    opcode = 6'h1C; funct = 6'h02;
    do_reset(); cyc(); cyc();
    chk("mul_ctrl", a_alu_ctrl, 4'd3);
    cyc();
    chk("mul_wb", a_reg_we, 1'b1);
    opcode = 6'h00; funct = 6'h02;
    do_reset(); cyc(); cyc();
    chk("srl_ctrl", a_alu_ctrl, 4'd9);
    funct = 6'h3F;
    do_reset(); cyc(); cyc();
    chk("bad_funct_ctrl", a_alu_ctrl, 4'd0);
    cyc();
    chk("bad_funct_fault", a_fault, 1'b1);
    chk("bad_funct_reg_we", a_reg_we, 1'b0);

    // Illegal opcode, then async reset out of FAULT
    opcode = 6'h3F; funct = 6'h20;
    do_reset(); cyc(); cyc();
    chk("ill_fault", a_fault, 1'b1);
    chk("ill_mem_req", a_mem_req, 1'b0);
    chk("ill_pc_we", a_pc_we, 1'b0);
    chk("ill_alu_en", a_alu_en, 1'b0);
    cyc();
    chk("ill_fault_sticky", a_fault, 1'b1);
    rst = 1'b1;
    #1;
    chk("ill_rst_fault", a_fault, 1'b0);
    chk("ill_rst_req", a_mem_req, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("ill_rst_refetch", a_mem_req, 1'b1);

    // Overflow handling
    opcode = 6'h00; funct = 6'h20; overflow_f = 1'b1;
    do_reset(); cyc(); cyc();
    chk("ovf_add_ex_reg_we", a_reg_we, 1'b0);
    cyc();
`ifdef MIPS_CTRL_OVF_TRAP_EN
    chk("ovf_add_fault", a_fault, 1'b1);
    chk("ovf_add_reg_we", a_reg_we, 1'b0);
`else
    chk("ovf_add_fault", a_fault, 1'b0);
    chk("ovf_add_reg_we", a_reg_we, 1'b1);
`endif
    opcode = 6'h08;
    do_reset(); cyc(); cyc(); cyc();
`ifdef MIPS_CTRL_OVF_TRAP_EN
    chk("ovf_addi_fault", a_fault, 1'b1);
    chk("ovf_addi_reg_we", a_reg_we, 1'b0);
`else
    chk("ovf_addi_fault", a_fault, 1'b0);
    chk("ovf_addi_reg_we", a_reg_we, 1'b1);
`endif
    // Shifts never trap on overflow
    opcode = 6'h00; funct = 6'h00;
    do_reset(); cyc(); cyc(); cyc();
    chk("ovf_sll_reg_we", a_reg_we, 1'b1);
    chk("ovf_sll_fault", a_fault, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
